control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle sequencer that drives the `datapath` control inputs, which benches currently drive by hand. It steps through T0–T7 once per clock, decodes the opcode latched in IR, and asserts the register-transfer, memory and ALU strobes for each instruction class. It sits directly upstream of `datapath`, with a one-to-one port match on every control line.

## Interface
- No parameters. Opcode and state encodings come from `cpu_pkg`.
- `clk`  in  1  system clock; all state changes occur on the rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `ir_op`  in  5  IR[31:27], from the datapath IR register.
- `CON_FF`  in  1  branch-condition flip-flop output from the datapath.
- `run`  out  1  high while executing; low after HALT.
- Register-transfer strobes, each `out 1`: `PCout`, `Zlowout`, `Zhighout`, `MDRout`, `Cout`, `BAout`, `Rout`, `LOout`, `HIout`, `IN_Portout`.
- Register-load strobes, each `out 1`: `MARIn`, `PCIn`, `MDRIn`, `IRIn`, `YIn`, `ZIn`, `HiIn`, `LoIn`, `CIn`, `InIn`, `OutIn`, `CONIn`, `RIn`.
- Register-select strobes, each `out 1`: `Gra`, `Grb`, `Grc`.
- Memory strobes, each `out 1`: `IncPC`, `read`, `write`.
- ALU operation strobes, each `out 1`, one-hot or all zero: `add`, `subtract`, `multiply`, `divide`, `and_op`, `or_op`.

## Operation
- States: `S_RST`, T0–T7, `S_HALT`. The state is held in a 4-bit register.
- Outputs are Moore-style: decoded from the current state and `ir_op` only. The single exception is `PCIn` in branch T6, which is additionally gated by `CON_FF`.
- Any output not listed for a state is 0.
- Fetch, common to all instructions:
  - T0: PCout, MARIn, IncPC, ZIn.
  - T1: Zlowout, PCIn, read, MDRIn.
  - T2: MDRout, IRIn.
- add/sub/and/or:
  - T3: Grb, Rout, YIn.
  - T4: Grc, Rout, op, ZIn.
  - T5: Zlowout, Gra, RIn.
  - Then T0.
- addi/andi/ori: same as add/sub/and/or, except T4 uses Cout in place of Grc/Rout. The op strobe is add, and_op or or_op respectively.
- mul/div:
  - T3: Gra, Rout, YIn.
  - T4: Grb, Rout, op, ZIn.
  - T5: Zlowout, LoIn.
  - T6: Zhighout, HiIn.
  - Then T0.
- ldi:
  - T3: Grb, BAout, YIn.
  - T4: Cout, add, ZIn.
  - T5: Zlowout, Gra, RIn.
  - Then T0.
- ld:
  - T3–T4: as ldi.
  - T5: Zlowout, MARIn.
  - T6: read, MDRIn.
  - T7: MDRout, Gra, RIn.
  - Then T0.
- st:
  - T3–T5: as ld.
  - T6: Gra, Rout, MDRIn.
  - T7: write.
  - Then T0.
- br:
  - T3: Gra, Rout, CONIn.
  - T4: PCout, YIn.
  - T5: Cout, add, ZIn.
  - T6: Zlowout, plus PCIn only if CON_FF=1.
  - Then T0.
- nop and every undefined opcode: T2 goes directly to T0, with no side effects.
- halt: T2 goes to `S_HALT`. `run` drops to 0 and all strobes stay 0 until reset.

## Timing
- Reset (`clr`=0):
  - The state goes to `S_RST` immediately (asynchronous).
  - Every output is 0, including `run`.
  - This also applies mid-instruction: a partially executed st never asserts `write`.
- Reset release: the first rising edge after `clr`=1 moves `S_RST` to T0. `run` is 1 from T0 onward.
- Each T-state lasts exactly one clock.
- Instruction latency, counted from T0 entry to the next T0: ALU reg/imm and ldi take 6 cycles; mul/div and br take 7; ld and st take 8; nop takes 3.
- `ir_op` is sampled only in T3–T7 and at the T2 exit decision. IR loads at the end of T2, so decode uses the new opcode from T3 on.
- The T2 exit decision must use the value IR will hold, i.e. the MDR contents. It therefore takes `ir_op` combinationally from the IR input path provided by the datapath. This requires `IRIn` and `MDRout` in T2 to make the new opcode visible before the edge.
- Memory is combinational: `read` with `MDRIn` captures data on the same edge.
- `CON_FF` is sampled combinationally during T6 of br only.
- At most one ALU op strobe is high in any cycle.
- `read` and `write` are never high in the same cycle.

## Structure
- `cpu_pkg` holds the 5-bit opcode localparams. These are the only opcodes; everything else decodes as nop:
  - ld=00000, ldi=00001, st=00010
  - add=00011, sub=00100, and=00101, or=00110
  - addi=01011, andi=01100, ori=01101
  - mul=01110, div=01111
  - br=10010, nop=11001, halt=11010
- `cpu_pkg` also holds the state encodings. These reuse the bench values T0=0111 … T7=1110, plus S_RST=0000 and S_HALT=1111.
- Sub-module `op_class_decode` (combinational) maps `ir_op` to a one-hot class: ALU_R, ALU_I, MULDIV, LDI, LD, ST, BR, NOP, HALT. It also outputs the ALU op select. `control_unit` contains only the state register and the output decode per class.

## Test plan
- Reset sequencing: hold `clr`=0 for 3 cycles, then release → all outputs 0 during reset; T0 strobes (PCout, MARIn, IncPC, ZIn) on cycle 1 after release; `run`=1.
- andi (01100):
  - T3: Grb, Rout, YIn.
  - T4: Cout, and_op, ZIn.
  - T5: Zlowout, Gra, RIn.
  - T0 recurs 6 cycles after the previous T0.
- st (00010): write=1 only in T7 and read=0 in T7. Assert `clr`=0 during T6 → write never asserts and the state returns to `S_RST`.
- br (10010):
  - With CON_FF=1: PCIn=1 in T6.
  - With CON_FF=0: PCIn=0 in T6 and Zlowout=1.
  - Both cases: next state T0.
- mul (01110): LoIn in T5 then HiIn in T6; multiply=1 only in T4; latency 7 cycles.
- Undefined opcode 11111 → T2 goes to T0, with no RIn/write/PCIn after T1. halt (11010) → `run`=0 and all strobes 0 for 20 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path.
//   - 5-bit opcodes (IR[31:27]); anything not listed here decodes as nop
//   - 4-bit sequencer state encodings (T0..T7 reuse the legacy bench values)
//   - one-hot instruction class and ALU op select produced by op_class_decode
//   - ctrl_t: the full control-strobe bundle driven into the datapath
package cpu_pkg;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned STATE_W = 4;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  // Sequencer states; T0..T7 are contiguous so a range check identifies them
  localparam logic [STATE_W-1:0] S_RST  = 4'b0000;
  localparam logic [STATE_W-1:0] S_T0   = 4'b0111;
  localparam logic [STATE_W-1:0] S_T1   = 4'b1000;
  localparam logic [STATE_W-1:0] S_T2   = 4'b1001;
  localparam logic [STATE_W-1:0] S_T3   = 4'b1010;
  localparam logic [STATE_W-1:0] S_T4   = 4'b1011;
  localparam logic [STATE_W-1:0] S_T5   = 4'b1100;
  localparam logic [STATE_W-1:0] S_T6   = 4'b1101;
  localparam logic [STATE_W-1:0] S_T7   = 4'b1110;
  localparam logic [STATE_W-1:0] S_HALT = 4'b1111;

  // ALU operation requested by an instruction
  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_MUL  = 3'd3,
    ALU_DIV  = 3'd4,
    ALU_AND  = 3'd5,
    ALU_OR   = 3'd6
  } alu_sel_e;

  // One-hot instruction class
  typedef struct packed {
    logic alu_r;
    logic alu_i;
    logic muldiv;
    logic ldi;
    logic ld;
    logic st;
    logic br;
    logic nop;
    logic halt;
  } op_class_t;

  // Complete control-strobe bundle toward the datapath
  typedef struct packed {
    logic run;
    // register-transfer (bus drive)
    logic pc_out;
    logic zlow_out;
    logic zhigh_out;
    logic mdr_out;
    logic c_out;
    logic ba_out;
    logic r_out;
    logic lo_out;
    logic hi_out;
    logic in_port_out;
    // register loads
    logic mar_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic hi_in;
    logic lo_in;
    logic c_in;
    logic in_in;
    logic out_in;
    logic con_in;
    logic r_in;
    // register-field selects
    logic gra;
    logic grb;
    logic grc;
    // memory
    logic inc_pc;
    logic read;
    logic write;
    // ALU op strobes (one-hot or zero)
    logic add;
    logic subtract;
    logic multiply;
    logic divide;
    logic and_op;
    logic or_op;
  } ctrl_t;

  // Raise exactly one ALU strobe for the selected op; ALU_NONE leaves all low
  function automatic ctrl_t with_alu(input ctrl_t c, input alu_sel_e sel);
    ctrl_t r;
    r = c;
    case (sel)
      ALU_ADD: r.add      = 1'b1;
      ALU_SUB: r.subtract = 1'b1;
      ALU_MUL: r.multiply = 1'b1;
      ALU_DIV: r.divide   = 1'b1;
      ALU_AND: r.and_op   = 1'b1;
      ALU_OR:  r.or_op    = 1'b1;
      default: r          = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier.
//   ir_op_i    : IR[31:27]
//   op_class_o : one-hot instruction class (undefined opcodes -> nop)
//   alu_sel_o  : ALU operation the instruction's execute step needs
module op_class_decode
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] ir_op_i,
  output op_class_t       op_class_o,
  output alu_sel_e        alu_sel_o
);

  // Opcode -> class / ALU op; default path treats unknown opcodes as nop
  always_comb begin
    op_class_o = '0;
    alu_sel_o  = ALU_NONE;
    case (ir_op_i)
      OP_LD:   begin op_class_o.ld     = 1'b1; alu_sel_o = ALU_ADD; end
      OP_LDI:  begin op_class_o.ldi    = 1'b1; alu_sel_o = ALU_ADD; end
      OP_ST:   begin op_class_o.st     = 1'b1; alu_sel_o = ALU_ADD; end
      OP_ADD:  begin op_class_o.alu_r  = 1'b1; alu_sel_o = ALU_ADD; end
      OP_SUB:  begin op_class_o.alu_r  = 1'b1; alu_sel_o = ALU_SUB; end
      OP_AND:  begin op_class_o.alu_r  = 1'b1; alu_sel_o = ALU_AND; end
      OP_OR:   begin op_class_o.alu_r  = 1'b1; alu_sel_o = ALU_OR;  end
      OP_ADDI: begin op_class_o.alu_i  = 1'b1; alu_sel_o = ALU_ADD; end
      OP_ANDI: begin op_class_o.alu_i  = 1'b1; alu_sel_o = ALU_AND; end
      OP_ORI:  begin op_class_o.alu_i  = 1'b1; alu_sel_o = ALU_OR;  end
      OP_MUL:  begin op_class_o.muldiv = 1'b1; alu_sel_o = ALU_MUL; end
      OP_DIV:  begin op_class_o.muldiv = 1'b1; alu_sel_o = ALU_DIV; end
      OP_BR:   begin op_class_o.br     = 1'b1; alu_sel_o = ALU_ADD; end
      OP_HALT: op_class_o.halt = 1'b1;
      OP_NOP:  op_class_o.nop  = 1'b1;
      default: op_class_o.nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control sequencer for the datapath.
// Steps T0..T7 once per clock, fetching in T0..T2 and executing per the
// instruction class decoded from ir_op. Strobes are a Moore decode of the
// state register and ir_op; PCIn in branch T6 is additionally gated by CON_FF.
//   clk, clr (async active-low reset)
//   ir_op  : IR[31:27]; in T2 this is the IR input path (value being loaded)
//   CON_FF : branch condition from the datapath
//   run    : high in T0..T7, low in reset and after HALT
//   all other outputs: datapath control strobes, matched one-to-one by name
module control_unit
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic [OP_W-1:0] ir_op,
  input  logic            CON_FF,
  output logic            run,
  output logic            PCout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            MDRout,
  output logic            Cout,
  output logic            BAout,
  output logic            Rout,
  output logic            LOout,
  output logic            HIout,
  output logic            IN_Portout,
  output logic            MARIn,
  output logic            PCIn,
  output logic            MDRIn,
  output logic            IRIn,
  output logic            YIn,
  output logic            ZIn,
  output logic            HiIn,
  output logic            LoIn,
  output logic            CIn,
  output logic            InIn,
  output logic            OutIn,
  output logic            CONIn,
  output logic            RIn,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            IncPC,
  output logic            read,
  output logic            write,
  output logic            add,
  output logic            subtract,
  output logic            multiply,
  output logic            divide,
  output logic            and_op,
  output logic            or_op
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  op_class_t          op_class;
  alu_sel_e           alu_sel;
  ctrl_t              ctrl;
  logic               in_t_state;

  op_class_decode u_decode (
    .ir_op_i    (ir_op),
    .op_class_o (op_class),
    .alu_sel_o  (alu_sel)
  );

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fetch is common; exit point depends on instruction class
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2: begin
        if (op_class.halt) begin
          state_d = S_HALT;
        end else if (op_class.nop) begin
          state_d = S_T0;
        end else begin
          state_d = S_T3;
        end
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: begin
        if (op_class.muldiv || op_class.br || op_class.ld || op_class.st) begin
          state_d = S_T6;
        end else begin
          state_d = S_T0;
        end
      end
      S_T6: begin
        if (op_class.ld || op_class.st) begin
          state_d = S_T7;
        end else begin
          state_d = S_T0;
        end
      end
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  assign in_t_state = (state_q >= S_T0) && (state_q <= S_T7);

  // Strobe decode per state and class; everything not raised stays 0
  always_comb begin
    ctrl     = '0;
    ctrl.run = in_t_state;
    case (state_q)
      S_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
      end
      S_T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      S_T3: begin
        if (op_class.alu_r || op_class.alu_i) begin
          ctrl.grb   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.y_in  = 1'b1;
        end else if (op_class.muldiv) begin
          ctrl.gra   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.y_in  = 1'b1;
        end else if (op_class.ldi || op_class.ld || op_class.st) begin
          // Base address: R[rb], or 0 when rb is r0 (handled by BAout)
          ctrl.grb    = 1'b1;
          ctrl.ba_out = 1'b1;
          ctrl.y_in   = 1'b1;
        end else if (op_class.br) begin
          ctrl.gra    = 1'b1;
          ctrl.r_out  = 1'b1;
          ctrl.con_in = 1'b1;
        end
      end
      S_T4: begin
        if (op_class.alu_r) begin
          ctrl.grc   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.z_in  = 1'b1;
          ctrl       = with_alu(ctrl, alu_sel);
        end else if (op_class.alu_i) begin
          ctrl.c_out = 1'b1;
          ctrl.z_in  = 1'b1;
          ctrl       = with_alu(ctrl, alu_sel);
        end else if (op_class.muldiv) begin
          ctrl.grb   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.z_in  = 1'b1;
          ctrl       = with_alu(ctrl, alu_sel);
        end else if (op_class.ldi || op_class.ld || op_class.st) begin
          ctrl.c_out = 1'b1;
          ctrl.z_in  = 1'b1;
          ctrl       = with_alu(ctrl, ALU_ADD);
        end else if (op_class.br) begin
          ctrl.pc_out = 1'b1;
          ctrl.y_in   = 1'b1;
        end
      end
      S_T5: begin
        if (op_class.alu_r || op_class.alu_i || op_class.ldi) begin
          ctrl.zlow_out = 1'b1;
          ctrl.gra      = 1'b1;
          ctrl.r_in     = 1'b1;
        end else if (op_class.muldiv) begin
          ctrl.zlow_out = 1'b1;
          ctrl.lo_in    = 1'b1;
        end else if (op_class.ld || op_class.st) begin
          ctrl.zlow_out = 1'b1;
          ctrl.mar_in   = 1'b1;
        end else if (op_class.br) begin
          // Branch target = PC + C
          ctrl.c_out = 1'b1;
          ctrl.z_in  = 1'b1;
          ctrl       = with_alu(ctrl, ALU_ADD);
        end
      end
      S_T6: begin
        if (op_class.muldiv) begin
          ctrl.zhigh_out = 1'b1;
          ctrl.hi_in     = 1'b1;
        end else if (op_class.ld) begin
          ctrl.read   = 1'b1;
          ctrl.mdr_in = 1'b1;
        end else if (op_class.st) begin
          ctrl.gra    = 1'b1;
          ctrl.r_out  = 1'b1;
          ctrl.mdr_in = 1'b1;
        end else if (op_class.br) begin
          // Target always on the bus; PC only loads when the condition holds
          ctrl.zlow_out = 1'b1;
          ctrl.pc_in    = CON_FF;
        end
      end
      S_T7: begin
        if (op_class.ld) begin
          ctrl.mdr_out = 1'b1;
          ctrl.gra     = 1'b1;
          ctrl.r_in    = 1'b1;
        end else if (op_class.st) begin
          ctrl.write = 1'b1;
        end
      end
      default: ctrl.run = 1'b0;
    endcase
  end

  // Port mapping
  assign run        = ctrl.run;
  assign PCout      = ctrl.pc_out;
  assign Zlowout    = ctrl.zlow_out;
  assign Zhighout   = ctrl.zhigh_out;
  assign MDRout     = ctrl.mdr_out;
  assign Cout       = ctrl.c_out;
  assign BAout      = ctrl.ba_out;
  assign Rout       = ctrl.r_out;
  assign LOout      = ctrl.lo_out;
  assign HIout      = ctrl.hi_out;
  assign IN_Portout = ctrl.in_port_out;
  assign MARIn      = ctrl.mar_in;
  assign PCIn       = ctrl.pc_in;
  assign MDRIn      = ctrl.mdr_in;
  assign IRIn       = ctrl.ir_in;
  assign YIn        = ctrl.y_in;
  assign ZIn        = ctrl.z_in;
  assign HiIn       = ctrl.hi_in;
  assign LoIn       = ctrl.lo_in;
  assign CIn        = ctrl.c_in;
  assign InIn       = ctrl.in_in;
  assign OutIn      = ctrl.out_in;
  assign CONIn      = ctrl.con_in;
  assign RIn        = ctrl.r_in;
  assign Gra        = ctrl.gra;
  assign Grb        = ctrl.grb;
  assign Grc        = ctrl.grc;
  assign IncPC      = ctrl.inc_pc;
  assign read       = ctrl.read;
  assign write      = ctrl.write;
  assign add        = ctrl.add;
  assign subtract   = ctrl.subtract;
  assign multiply   = ctrl.multiply;
  assign divide     = ctrl.divide;
  assign and_op     = ctrl.and_op;
  assign or_op      = ctrl.or_op;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver issues one cycle of stimulus
// at a time and pushes the expected strobe vector for that cycle; a monitor on
// the falling edge pops and compares every cycle.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] ir_op;
  logic       CON_FF;
  logic run, PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout, LOout, HIout;
  logic IN_Portout, MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, CIn, InIn;
  logic OutIn, CONIn, RIn, Gra, Grb, Grc, IncPC, read, write;
  logic add, subtract, multiply, divide, and_op, or_op;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .ir_op(ir_op), .CON_FF(CON_FF), .run(run),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .Cout(Cout), .BAout(BAout), .Rout(Rout), .LOout(LOout), .HIout(HIout),
    .IN_Portout(IN_Portout), .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn),
    .IRIn(IRIn), .YIn(YIn), .ZIn(ZIn), .HiIn(HiIn), .LoIn(LoIn), .CIn(CIn),
    .InIn(InIn), .OutIn(OutIn), .CONIn(CONIn), .RIn(RIn), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .read(read), .write(write),
    .add(add), .subtract(subtract), .multiply(multiply), .divide(divide),
    .and_op(and_op), .or_op(or_op)
  );

  // Bit positions of each strobe in the compared vector
  localparam logic [35:0] M_RUN   = 36'(1) << 35;
  localparam logic [35:0] M_PCO   = 36'(1) << 34;
  localparam logic [35:0] M_ZLO   = 36'(1) << 33;
  localparam logic [35:0] M_ZHI   = 36'(1) << 32;
  localparam logic [35:0] M_MDRO  = 36'(1) << 31;
  localparam logic [35:0] M_CO    = 36'(1) << 30;
  localparam logic [35:0] M_BAO   = 36'(1) << 29;
  localparam logic [35:0] M_RO    = 36'(1) << 28;
  localparam logic [35:0] M_MARI  = 36'(1) << 24;
  localparam logic [35:0] M_PCI   = 36'(1) << 23;
  localparam logic [35:0] M_MDRI  = 36'(1) << 22;
  localparam logic [35:0] M_IRI   = 36'(1) << 21;
  localparam logic [35:0] M_YI    = 36'(1) << 20;
  localparam logic [35:0] M_ZI    = 36'(1) << 19;
  localparam logic [35:0] M_HII   = 36'(1) << 18;
  localparam logic [35:0] M_LOI   = 36'(1) << 17;
  localparam logic [35:0] M_CONI  = 36'(1) << 13;
  localparam logic [35:0] M_RI    = 36'(1) << 12;
  localparam logic [35:0] M_GRA   = 36'(1) << 11;
  localparam logic [35:0] M_GRB   = 36'(1) << 10;
  localparam logic [35:0] M_GRC   = 36'(1) << 9;
  localparam logic [35:0] M_INCPC = 36'(1) << 8;
  localparam logic [35:0] M_READ  = 36'(1) << 7;
  localparam logic [35:0] M_WRITE = 36'(1) << 6;
  localparam logic [35:0] M_ADD   = 36'(1) << 5;
  localparam logic [35:0] M_SUB   = 36'(1) << 4;
  localparam logic [35:0] M_MUL   = 36'(1) << 3;
  localparam logic [35:0] M_DIV   = 36'(1) << 2;
  localparam logic [35:0] M_AND   = 36'(1) << 1;
  localparam logic [35:0] M_OR    = 36'(1) << 0;

  localparam logic [4:0] O_LD = 5'b00000, O_LDI = 5'b00001, O_ST = 5'b00010;
  localparam logic [4:0] O_ADD = 5'b00011, O_SUB = 5'b00100;
  localparam logic [4:0] O_AND = 5'b00101, O_OR = 5'b00110;
  localparam logic [4:0] O_ADDI = 5'b01011, O_ANDI = 5'b01100, O_ORI = 5'b01101;
  localparam logic [4:0] O_MUL = 5'b01110, O_DIV = 5'b01111;
  localparam logic [4:0] O_BR = 5'b10010, O_NOP = 5'b11001, O_HALT = 5'b11010;

  typedef struct {
    logic [35:0] exp;
    logic [4:0]  op;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [35:0] steps[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc_n    = 0;

  // Reference: list of per-cycle strobe sets for one instruction, T0 onward
  function automatic void build_steps(input logic [4:0] op, input logic con);
    logic [35:0] alu;
    steps.delete();
    steps.push_back(M_RUN | M_PCO | M_MARI | M_INCPC | M_ZI);
    steps.push_back(M_RUN | M_ZLO | M_PCI | M_READ | M_MDRI);
    steps.push_back(M_RUN | M_MDRO | M_IRI);
    case (op)
      O_ADD, O_SUB, O_AND, O_OR: begin
        alu = (op == O_ADD) ? M_ADD : (op == O_SUB) ? M_SUB :
              (op == O_AND) ? M_AND : M_OR;
        steps.push_back(M_RUN | M_GRB | M_RO | M_YI);
        steps.push_back(M_RUN | M_GRC | M_RO | alu | M_ZI);
        steps.push_back(M_RUN | M_ZLO | M_GRA | M_RI);
      end
      O_ADDI, O_ANDI, O_ORI: begin
        alu = (op == O_ADDI) ? M_ADD : (op == O_ANDI) ? M_AND : M_OR;
        steps.push_back(M_RUN | M_GRB | M_RO | M_YI);
        steps.push_back(M_RUN | M_CO | alu | M_ZI);
        steps.push_back(M_RUN | M_ZLO | M_GRA | M_RI);
      end
      O_MUL, O_DIV: begin
        alu = (op == O_MUL) ? M_MUL : M_DIV;
        steps.push_back(M_RUN | M_GRA | M_RO | M_YI);
        steps.push_back(M_RUN | M_GRB | M_RO | alu | M_ZI);
        steps.push_back(M_RUN | M_ZLO | M_LOI);
        steps.push_back(M_RUN | M_ZHI | M_HII);
      end
      O_LDI, O_LD, O_ST: begin
        steps.push_back(M_RUN | M_GRB | M_BAO | M_YI);
        steps.push_back(M_RUN | M_CO | M_ADD | M_ZI);
        if (op == O_LDI) begin
          steps.push_back(M_RUN | M_ZLO | M_GRA | M_RI);
        end else begin
          steps.push_back(M_RUN | M_ZLO | M_MARI);
          if (op == O_LD) begin
            steps.push_back(M_RUN | M_READ | M_MDRI);
            steps.push_back(M_RUN | M_MDRO | M_GRA | M_RI);
          end else begin
            steps.push_back(M_RUN | M_GRA | M_RO | M_MDRI);
            steps.push_back(M_RUN | M_WRITE);
          end
        end
      end
      O_BR: begin
        steps.push_back(M_RUN | M_GRA | M_RO | M_CONI);
        steps.push_back(M_RUN | M_PCO | M_YI);
        steps.push_back(M_RUN | M_CO | M_ADD | M_ZI);
        steps.push_back(M_RUN | M_ZLO | (con ? M_PCI : 36'(0)));
      end
      default: ; // nop, halt, undefined: fetch only
    endcase
  endfunction

  task automatic drive_cycle(input logic c, input logic [4:0] op,
                             input logic con, input logic [35:0] e);
    exp_t item;
    @(posedge clk);
    #1;
    clr    = c;
    ir_op  = op;
    CON_FF = con;
    cyc_n++;
    item.exp = e;
    item.op  = op;
    item.cyc = cyc_n;
    sb_q.push_back(item);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 5'($urandom), 1'($urandom), '0);
    // release: one more cycle in reset state before T0
    drive_cycle(1'b1, 5'($urandom), 1'($urandom), '0);
  endtask

  // Run the first n steps of an instruction (n < 0: all of them)
  task automatic exec(input logic [4:0] op, input logic con, input int n);
    logic [35:0] local_steps[$];
    logic [4:0]  opd;
    logic        cond;
    build_steps(op, con);
    local_steps = steps;
    for (int i = 0; i < local_steps.size(); i++) begin
      if (n >= 0 && i >= n) break;
      opd  = (i < 2) ? 5'($urandom) : op;   // IR not yet valid in T0/T1
      cond = (op == O_BR && i == 6) ? con : 1'($urandom);
      drive_cycle(1'b1, opd, cond, local_steps[i]);
    end
  endtask

  function automatic logic [4:0] rand_op();
    logic [4:0] o;
    o = 5'($urandom_range(0, 31));
    if (o == O_HALT) o = O_NOP;
    return o;
  endfunction

  // Monitor: compare every cycle against the scoreboard head
  always @(negedge clk) begin
    exp_t        e;
    logic [35:0] got;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = {run, PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout, LOout,
             HIout, IN_Portout, MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn,
             CIn, InIn, OutIn, CONIn, RIn, Gra, Grb, Grc, IncPC, read, write,
             add, subtract, multiply, divide, and_op, or_op};
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL strobes cycle=%0d ir_op=%b got=%h exp=%h",
                 e.cyc, e.op, got, e.exp);
      end
    end
  end

  initial begin
    clr    = 1'b0;
    ir_op  = '0;
    CON_FF = 1'b0;
    do_reset(3);

    exec(O_ANDI, 1'b0, -1);
    exec(O_ST,   1'b0, -1);
    exec(O_BR,   1'b1, -1);
    exec(O_BR,   1'b0, -1);
    exec(O_MUL,  1'b0, -1);
    exec(5'b11111, 1'b0, -1);
    exec(O_NOP,  1'b0, -1);
    exec(O_LD,   1'b0, -1);
    exec(O_LDI,  1'b0, -1);
    exec(O_DIV,  1'b0, -1);
    exec(O_ADDI, 1'b0, -1);
    exec(O_ORI,  1'b0, -1);

    for (int k = 0; k < 150; k++) exec(rand_op(), 1'($urandom), -1);

    // store interrupted by reset where T6 would begin
    exec(O_ST, 1'b0, 6);
    do_reset(3);
    exec(O_ADD, 1'b0, -1);

    // halt: everything stays low until reset
    exec(O_HALT, 1'b0, -1);
    for (int k = 0; k < 20; k++) drive_cycle(1'b1, 5'($urandom), 1'($urandom), '0);
    do_reset(2);
    exec(O_SUB, 1'b0, -1);
    exec(O_OR,  1'b0, -1);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d need=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
